// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage that sits directly behind program_counter. It takes the current
// PC, issues one instruction-memory request at a time, and parks each response
// together with its PC in a small FIFO. The FIFO feeds decode.
//
// Valid/ready semantics apply to both the imem request port and the decode
// port. A transfer happens on a rising edge where valid and ready are both 1.
// Once the producer raises valid, it holds valid and its payload stable until
// that transfer happens, except when a flush withdraws the request. Ready may
// be raised or lowered at any time. The imem response port has no ready:
// memory cannot be stalled, so a slot is reserved before each request issues.
//
// Parameters
//   size   address / instruction width in bits
//   DEPTH  output FIFO entries (power of two, >= 2)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous, active-low reset
//   pc_in           current PC from program_counter
//   flush           redirect; drops in-flight and buffered work
//   pc_advance      1-cycle pulse when a request is accepted (PC may step)
//   imem_req_valid  request valid toward instruction memory
//   imem_req_ready  memory accepts the request
//   imem_req_addr   request address (pc_in latched at issue)
//   imem_rsp_valid  response valid (never back-pressured)
//   imem_rsp_data   instruction word
//   if_valid        FIFO head valid toward decode
//   if_ready        decode accepts the head
//   if_pc           PC of the FIFO head
//   if_instr        instruction of the FIFO head
//   fsm_state       current fetch FSM state (debug visibility)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int size  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] pc_in,
  input  logic            flush,
  output logic            pc_advance,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [size-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [size-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [size-1:0] if_pc,
  output logic [size-1:0] if_instr,
  output logic [1:0]      fsm_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // The extra bit lets count plus the outstanding slot compare without
  // wrapping when the FIFO is already full.
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  // FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [size-1:0] addr_q;

  // FIFO storage and bookkeeping
  logic [size-1:0] mem_pc    [DEPTH];
  logic [size-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic            req_fire;
  logic            outstanding;
  logic [CNT_W:0]  committed;
  logic            issue_ok;
  logic            push;
  logic            pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = addr_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A flush in REQ cancels the request, so it must not step the PC even if
  // memory happens to show ready in the same cycle.
  assign pc_advance     = req_fire & ~flush;

  // A request in REQ or WAIT owns one FIFO slot. Its response is guaranteed
  // room because this slot is counted before the next request issues.
  // DISCARD does not own a slot because its response is dropped.
  assign outstanding = (state == S_REQ) || (state == S_WAIT);
  assign committed   = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
  assign issue_ok    = (state == S_IDLE) && !flush && (committed < DEPTH_LIM);

  // A response that meets a flush belongs to the old path and is dropped.
  assign push = (state == S_WAIT) & imem_rsp_valid & ~flush;

  // A pop in a flush cycle is ignored, because flush empties the FIFO anyway.
  assign pop  = if_valid & if_ready & ~flush;

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue_ok) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (flush)         state_nxt = S_IDLE;
        else if (req_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // With a same-cycle response the transaction is already closed, so
        // go back to IDLE. Without one, the late response still has to be
        // absorbed in DISCARD.
        if (imem_rsp_valid)  state_nxt = S_IDLE;
        else if (flush)      state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        // Only the stale response ends this state. Further flushes keep us
        // here because nothing new has been requested.
        if (imem_rsp_valid)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      // The address latches only on issue, so it stays put while REQ waits
      // for ready even if program_counter changes pc_in.
      if (issue_ok) addr_q <= pc_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is. The entries become unreachable once the
      // pointers and count clear.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= addr_q;
        mem_instr[wr_ptr] <= imem_rsp_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // push and pop together leave count unchanged. The credit check means a
      // push never lands on a full FIFO.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign if_valid = (count != '0);
  assign if_pc    = mem_pc[rd_ptr];
  assign if_instr = mem_instr[rd_ptr];

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. The bench plays both the PC stage and the
// instruction memory. Inputs are driven 1 time unit after the rising edge,
// and outputs are sampled 1 unit after that.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DISC = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pc_in = '0;
  logic         flush = 1'b0;
  logic         pc_advance;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [W-1:0] imem_rsp_data = '0;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  instr_fetch #(.size(W), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .flush          (flush),
    .pc_advance     (pc_advance),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fsm_state      (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int adv_cnt  = 0;
  logic [W-1:0] exp_q[$];

  // pc_advance pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (pc_advance) adv_cnt = adv_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit after an edge with rst released. That cycle is IDLE.
  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    pc_in = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // 1: reset values, asynchronous reset mid-WAIT, re-issue after release
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    pc_in = 32'h40;
    #1;
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL reset_pc_advance: got %b expected 0", pc_advance); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_req_addr); end
    n_checks++; if ({if_pc, if_instr} !== 64'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h expected 0/0", if_pc, if_instr); end
    step();
    imem_req_ready = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin n_fail++; $display("FAIL rst_first_req: got v=%b a=%h expected v=1 a=00000040", imem_req_valid, imem_req_addr); end
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1111_0040;
    pc_in = 32'h44;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_fail++; $display("FAIL rst_buffered: got v=%b pc=%h expected v=1 pc=00000040", if_valid, if_pc); end
    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #1;
    n_checks++; if (fsm_state !== ST_WAIT || if_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait: got st=%0d v=%b expected st=2 v=1", fsm_state, if_valid); end
    // assert reset between edges
    rst = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin n_fail++; $display("FAIL async_reset_outputs: got if_v=%b req_v=%b adv=%b expected 0/0/0", if_valid, imem_req_valid, pc_advance); end
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", fsm_state); end
    step();
    step();
    rst = 1'b1;
    pc_in = 32'h80;
    step();
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin n_fail++; $display("FAIL rst_reissue: got v=%b a=%h expected v=1 a=00000080", imem_req_valid, imem_req_addr); end
  endtask

  // ---------------------------------------------------------------------------
  // 2: zero-wait memory, three fetches in order
  // ---------------------------------------------------------------------------
  task automatic test_zero_wait();
    int adv0;
    logic [W-1:0] exp_pc;
    do_reset();
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    adv0 = adv_cnt;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'(4 * i);
      #1;
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL zw_idle_req_%0d: got %b expected 0", i, imem_req_valid); end
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (32'hC0DE_0000 | exp_pc)) begin n_fail++; $display("FAIL zw_head_%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", i, if_valid, if_pc, if_instr, exp_pc, 32'hC0DE_0000 | exp_pc); end
      end
      step();
      #1;
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i) || pc_advance !== 1'b1) begin n_fail++; $display("FAIL zw_req_%0d: got v=%b a=%h adv=%b expected v=1 a=%h adv=1", i, imem_req_valid, imem_req_addr, pc_advance, 32'(4 * i)); end
      exp_q.push_back(32'(4 * i));
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hC0DE_0000 | 32'(4 * i);
      #1;
      n_checks++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL zw_wait_adv_%0d: got %b expected 0", i, pc_advance); end
      step();
      imem_rsp_valid = 1'b0;
    end
    #1;
    exp_pc = exp_q.pop_front();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (32'hC0DE_0000 | exp_pc)) begin n_fail++; $display("FAIL zw_head_last: got v=%b pc=%h ins=%h expected v=1 pc=%h", if_valid, if_pc, if_instr, exp_pc); end
    n_checks++; if (adv_cnt - adv0 != 3) begin n_fail++; $display("FAIL zw_adv_pulses: got %0d expected 3", adv_cnt - adv0); end
  endtask

  // ---------------------------------------------------------------------------
  // 3: FIFO fills with if_ready low, credit holds back a third request
  // ---------------------------------------------------------------------------
  task automatic test_fifo_full();
    do_reset();
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    pc_in = 32'h10;
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hD000_0010;
    step();
    imem_rsp_valid = 1'b0;
    pc_in = 32'h14;
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hD000_0014;
    step();
    imem_rsp_valid = 1'b0;
    pc_in = 32'h18;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (imem_req_valid !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL full_no_req_%0d: got v=%b st=%0d expected v=0 st=0", k, imem_req_valid, fsm_state); end
      step();
    end
    if_ready = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'hD000_0010) begin n_fail++; $display("FAIL full_head0: got v=%b pc=%h ins=%h expected v=1 pc=00000010 ins=d0000010", if_valid, if_pc, if_instr); end
    step();
    if_ready = 1'b0;
    #1;
    n_checks++; if (if_pc !== 32'h14 || if_instr !== 32'hD000_0014 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_after_pop: got pc=%h ins=%h req_v=%b expected pc=00000014 ins=d0000014 req_v=0", if_pc, if_instr, imem_req_valid); end
    step();
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h18) begin n_fail++; $display("FAIL full_resume_req: got v=%b a=%h expected v=1 a=00000018", imem_req_valid, imem_req_addr); end
    step();
    // push and pop in the same cycle with one entry buffered
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hD000_0018;
    if_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    if_ready = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h18 || if_instr !== 32'hD000_0018) begin n_fail++; $display("FAIL push_pop_same: got v=%b pc=%h ins=%h expected v=1 pc=00000018 ins=d0000018", if_valid, if_pc, if_instr); end
  endtask

  // ---------------------------------------------------------------------------
  // 4: memory stalls the request for 5 cycles
  // ---------------------------------------------------------------------------
  task automatic test_req_stall();
    int adv0;
    do_reset();
    pc_in = 32'h20;
    adv0 = adv_cnt;
    step();
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b0;
      pc_in = 32'h24 + 32'(4 * i);
      #1;
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || pc_advance !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: got v=%b a=%h adv=%b expected v=1 a=00000020 adv=0", i, imem_req_valid, imem_req_addr, pc_advance); end
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    n_checks++; if (pc_advance !== 1'b1 || imem_req_addr !== 32'h20) begin n_fail++; $display("FAIL stall_accept: got adv=%b a=%h expected adv=1 a=00000020", pc_advance, imem_req_addr); end
    step();
    imem_req_ready = 1'b0;
    #1;
    n_checks++; if (fsm_state !== ST_WAIT || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_to_wait: got st=%0d v=%b expected st=2 v=0", fsm_state, imem_req_valid); end
    n_checks++; if (adv_cnt - adv0 != 1) begin n_fail++; $display("FAIL stall_adv_pulses: got %0d expected 1", adv_cnt - adv0); end
  endtask

  // ---------------------------------------------------------------------------
  // 5: flush in WAIT, stale response two cycles later is dropped
  // ---------------------------------------------------------------------------
  task automatic test_flush_wait();
    do_reset();
    pc_in = 32'h30;
    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++; if (fsm_state !== ST_WAIT) begin n_fail++; $display("FAIL fw_in_wait: got %0d expected 2", fsm_state); end
    step();
    flush = 1'b0;
    pc_in = 32'h100;
    #1;
    n_checks++; if (fsm_state !== ST_DISC || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fw_discard: got st=%0d v=%b expected st=3 v=0", fsm_state, imem_req_valid); end
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0BAD;
    #1;
    n_checks++; if (fsm_state !== ST_DISC) begin n_fail++; $display("FAIL fw_still_discard: got %0d expected 3", fsm_state); end
    step();
    imem_rsp_valid = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL fw_dropped: got v=%b st=%0d expected v=0 st=0", if_valid, fsm_state); end
    step();
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL fw_new_addr: got v=%b a=%h expected v=1 a=00000100", imem_req_valid, imem_req_addr); end
  endtask

  // ---------------------------------------------------------------------------
  // 6: flush together with a response and a pop; then flush on a full FIFO
  // ---------------------------------------------------------------------------
  task automatic test_flush_collide();
    do_reset();
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    pc_in = 32'h50;
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hE000_0050;
    step();
    imem_rsp_valid = 1'b0;
    pc_in = 32'h54;
    step();
    step();
    // WAIT with one entry buffered and one response due: credit is fully used
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hE000_0054;
    flush = 1'b1;
    if_ready = 1'b1;
    #1;
    n_checks++; if (fsm_state !== ST_WAIT || if_valid !== 1'b1) begin n_fail++; $display("FAIL fc_setup: got st=%0d v=%b expected st=2 v=1", fsm_state, if_valid); end
    step();
    imem_rsp_valid = 1'b0;
    flush = 1'b0;
    if_ready = 1'b0;
    imem_req_ready = 1'b0;
    pc_in = 32'h60;
    #1;
    n_checks++; if (if_valid !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL fc_cleared: got v=%b st=%0d expected v=0 st=0", if_valid, fsm_state); end
    step();
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h60) begin n_fail++; $display("FAIL fc_no_push: got if_v=%b req_v=%b a=%h expected 0/1/00000060", if_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hE000_0060;
    step();
    imem_rsp_valid = 1'b0;
    pc_in = 32'h64;
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hE000_0064;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h60 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL fc_full: got v=%b pc=%h st=%0d expected v=1 pc=00000060 st=0", if_valid, if_pc, fsm_state); end
    flush = 1'b1;
    if_ready = 1'b1;
    step();
    flush = 1'b0;
    if_ready = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL fc_full_flush: got v=%b st=%0d expected v=0 st=0", if_valid, fsm_state); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_zero_wait();
    test_fifo_full();
    test_req_stall();
    test_flush_wait();
    test_flush_collide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
